// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared types and constants for the IF-stage next-PC sequencer.
// Revision : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pcseq_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Purpose  : PC register, redirect/stall and instruction-memory handshake
//            bundle between the next-PC sequencer and the IF-stage context.
// Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic [XLEN-1:0] pc_q;
  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            jmp;
  logic [XLEN-1:0] jmp_target;
  logic            imem_req;
  logic            imem_ready;
  logic [XLEN-1:0] pc_next;
  logic            pc_we;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            misalign_err;

  // Sequencer side
  modport master (
    input  pc_q, stall, br_taken, br_target, jmp, jmp_target, imem_ready,
    output imem_req, pc_next, pc_we, if_id_flush, id_ex_flush, misalign_err
  );

  // Pipeline / memory side
  modport slave (
    output pc_q, stall, br_taken, br_target, jmp, jmp_target, imem_ready,
    input  imem_req, pc_next, pc_we, if_id_flush, id_ex_flush, misalign_err
  );

endinterface
`default_nettype wire

// File: rtl/pc_target_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_sel
// Purpose  : Combinational redirect arbiter: branch beats jump, target is
//            word-aligned, or replaced by TRAP_VEC when PCSEQ_TRAP_EN is
//            defined and the target is misaligned.
// Revision : 1.0  initial release
// ============================================================================
module pc_target_sel
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  wire logic            br_taken,
  input  wire logic [XLEN-1:0] br_target,
  input  wire logic            jmp,
  input  wire logic [XLEN-1:0] jmp_target,
  output logic                 redirect,
  output logic [XLEN-1:0]      target,
  output logic                 is_branch,
  output logic                 misalign
);

  logic [XLEN-1:0] w_raw;

  // Branch resolved in EX is older than the jump in ID, so it wins
  always_comb begin
    redirect  = br_taken | jmp;
    is_branch = br_taken;
    w_raw     = br_taken ? br_target : jmp_target;
  end

`ifdef PCSEQ_TRAP_EN
  // Misaligned targets are diverted to the trap handler
  always_comb begin
    misalign = redirect && (w_raw[1:0] != 2'b00);
    target   = misalign ? TRAP_VEC : w_raw;
  end
`else
  logic [XLEN+1:0] w_unused_bits;

  // Low target bits are dropped silently; the trap vector has no role here
  always_comb begin
    misalign      = 1'b0;
    target        = {w_raw[XLEN-1:2], 2'b00};
    w_unused_bits = {TRAP_VEC, w_raw[1:0]};
  end
`endif

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : IF-stage next-PC controller. Sequences the PC through boot,
//            sequential fetch, stalls and redirects while keeping the PC
//            stable for the whole of every outstanding fetch request.
//            Optional macro PCSEQ_TRAP_EN: misaligned redirect targets go to
//            TRAP_VEC and pulse misalign_err.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pc_sequencer_if.master bus
);

  pcseq_state_t    r_state;
  pcseq_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pend_pc;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_is_branch;
  logic            w_misalign;

  pc_target_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_target_sel (
    .br_taken   (bus.br_taken),
    .br_target  (bus.br_target),
    .jmp        (bus.jmp),
    .jmp_target (bus.jmp_target),
    .redirect   (w_redirect),
    .target     (w_target),
    .is_branch  (w_is_branch),
    .misalign   (w_misalign)
  );

  // State register; reset always restarts from BOOT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_nxt;
  end

  // Hold the redirect target while the in-flight fetch drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pend_pc <= '0;
    else if (r_state == RUN && w_redirect && !bus.imem_ready)
      r_pend_pc <= w_target;
  end

  // Next-state and output decode; PC only loads when the fetch completes
  always_comb begin
    w_state_nxt      = r_state;
    bus.pc_next      = bus.pc_q;
    bus.pc_we        = 1'b0;
    bus.imem_req     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.misalign_err = 1'b0;
    if (rst) begin
      bus.pc_next = RESET_VEC;
    end else begin
      case (r_state)
        BOOT: begin
          bus.pc_next = RESET_VEC;
          bus.pc_we   = 1'b1;
          w_state_nxt = RUN;
        end
        RUN: begin
          bus.imem_req = 1'b1;
          if (w_redirect) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = w_is_branch;
            bus.misalign_err = w_misalign;
            if (bus.imem_ready) begin
              bus.pc_next = w_target;
              bus.pc_we   = 1'b1;
            end else begin
              w_state_nxt = DRAIN;
            end
          end else if (!bus.stall && bus.imem_ready) begin
            bus.pc_next = bus.pc_q + XLEN'(INSTR_BYTES);
            bus.pc_we   = 1'b1;
          end
        end
        DRAIN: begin
          bus.imem_req = 1'b1;
          if (bus.imem_ready) begin
            bus.pc_next     = r_pend_pc;
            bus.pc_we       = 1'b1;
            bus.if_id_flush = 1'b1;
            w_state_nxt     = RUN;
          end
        end
        default: w_state_nxt = BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VEC (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the full output vector in one call
  task automatic chk_out(input string tag, input logic [31:0] nxt, input logic we,
                         input logic req, input logic f1, input logic f2, input logic me);
    chk({tag, ".pc_next"}, bus.pc_next, nxt);
    chk({tag, ".pc_we"}, {31'd0, bus.pc_we}, {31'd0, we});
    chk({tag, ".imem_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    chk({tag, ".if_id_flush"}, {31'd0, bus.if_id_flush}, {31'd0, f1});
    chk({tag, ".id_ex_flush"}, {31'd0, bus.id_ex_flush}, {31'd0, f2});
    chk({tag, ".misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, me});
  endtask

  task automatic drive(input logic [31:0] pc, input logic st, input logic br,
                       input logic [31:0] brt, input logic jp, input logic [31:0] jpt,
                       input logic rdy);
    bus.pc_q       = pc;
    bus.stall      = st;
    bus.br_taken   = br;
    bus.br_target  = brt;
    bus.jmp        = jp;
    bus.jmp_target = jpt;
    bus.imem_ready = rdy;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(32'h0, 0, 0, 32'h0, 0, 32'h0, 0);

    // Reset held: everything quiet, pc_next shows RESET_VEC
    @(negedge clk); #1;
    chk_out("reset", 32'h0, 0, 0, 0, 0, 0);

    // BOOT cycle
    @(negedge clk); rst = 1'b0; #1;
    chk_out("boot", 32'h0, 1, 0, 0, 0, 0);

    // Sequential fetch, one per cycle
    @(negedge clk); drive(32'h0, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("seq0", 32'h4, 1, 1, 0, 0, 0);
    @(negedge clk); drive(32'h4, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("seq1", 32'h8, 1, 1, 0, 0, 0);
    @(negedge clk); drive(32'h8, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("seq2", 32'hC, 1, 1, 0, 0, 0);
    @(negedge clk); drive(32'hC, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("seq3", 32'h10, 1, 1, 0, 0, 0);

    // Branch and jump together: branch wins, both flushes
    @(negedge clk); drive(32'h10, 0, 1, 32'h40, 1, 32'h80, 1); #1;
    chk_out("br_over_jmp", 32'h40, 1, 1, 1, 1, 0);
    @(negedge clk); drive(32'h40, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("after_br", 32'h44, 1, 1, 0, 0, 0);

    // Memory not ready, no redirect: address held
    @(negedge clk); drive(32'h44, 0, 0, 32'h0, 0, 32'h0, 0); #1;
    chk_out("hold", 32'h44, 0, 1, 0, 0, 0);

    // Jump while fetch outstanding: capture, then DRAIN
    @(negedge clk); drive(32'h44, 0, 0, 32'h0, 1, 32'h200, 0); #1;
    chk_out("jmp_capture", 32'h44, 0, 1, 1, 0, 0);
    @(negedge clk); drive(32'h44, 1, 1, 32'h500, 1, 32'h600, 0); #1;
    chk_out("drain1", 32'h44, 0, 1, 0, 0, 0);
    @(negedge clk); drive(32'h44, 0, 0, 32'h0, 0, 32'h0, 0); #1;
    chk_out("drain2", 32'h44, 0, 1, 0, 0, 0);
    @(negedge clk); drive(32'h44, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("drain_done", 32'h200, 1, 1, 1, 0, 0);

    // Stall for two cycles at 0x20
    @(negedge clk); drive(32'h20, 1, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("stall1", 32'h20, 0, 1, 0, 0, 0);
    @(negedge clk); drive(32'h20, 1, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("stall2", 32'h20, 0, 1, 0, 0, 0);
    @(negedge clk); drive(32'h20, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("unstall", 32'h24, 1, 1, 0, 0, 0);

    // Address wrap
    @(negedge clk); drive(32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("wrap", 32'h0, 1, 1, 0, 0, 0);

    // Misaligned branch target
    @(negedge clk); drive(32'h0, 0, 1, 32'h42, 0, 32'h0, 1); #1;
`ifdef PCSEQ_TRAP_EN
    chk_out("misalign", 32'h100, 1, 1, 1, 1, 1);
`else
    chk_out("misalign", 32'h40, 1, 1, 1, 1, 0);
`endif

    // Misaligned jump captured into DRAIN
    @(negedge clk); drive(32'h40, 0, 0, 32'h0, 1, 32'h303, 0); #1;
`ifdef PCSEQ_TRAP_EN
    chk_out("misalign_cap", 32'h40, 0, 1, 1, 0, 1);
`else
    chk_out("misalign_cap", 32'h40, 0, 1, 1, 0, 0);
`endif

    // Asynchronous reset mid-DRAIN discards the pending target
    @(negedge clk); drive(32'h40, 0, 0, 32'h0, 0, 32'h0, 0); #1;
    chk_out("drain_pre_rst", 32'h40, 0, 1, 0, 0, 0);
    #2 rst = 1'b1; #1;
    chk_out("rst_async", 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk_out("reboot", 32'h0, 1, 0, 0, 0, 0);
    @(negedge clk); drive(32'h0, 0, 0, 32'h0, 0, 32'h0, 1); #1;
    chk_out("post_rst_run", 32'h4, 1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the IF stage. It drives the 32-bit PC register's data input and write enable, and sequences the PC through boot, sequential fetch, stalls and redirects.
- It owns the instruction-memory request handshake, so the PC never changes while a fetch is outstanding.
- It arbitrates EX-stage branch redirects, ID-stage jump redirects and hazard-unit stalls, and generates the pipeline flushes.

Parameters:
- RESET_VEC, 32'h0000_0000, address loaded into the PC in the BOOT cycle.
- TRAP_VEC, 32'h0000_0100, misaligned-target handler address; used only with PCSEQ_TRAP_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_q  in  32  current PC from the PC register.
- stall  in  1  hazard-unit load-use stall.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  32  EX-stage branch target.
- jmp  in  1  ID-stage unconditional jump.
- jmp_target  in  32  ID-stage jump target.
- imem_req  out  1  fetch request at address pc_q.
- imem_ready  in  1  instruction memory returns data this cycle; completes the request.
- pc_next  out  32  data input to the PC register.
- pc_we  out  1  PC register load enable.
- if_id_flush  out  1  squash the IF/ID register.
- id_ex_flush  out  1  squash the ID/EX register.
- misalign_err  out  1  one-cycle pulse on a misaligned target; only with PCSEQ_TRAP_EN, otherwise tied 0.

Behaviour:
- State machine: BOOT, RUN, DRAIN.
- Register: pend_pc (32 bits).
- Reset:
  - rst high sets state=BOOT and pend_pc=0.
  - While rst is high: pc_we=0, imem_req=0, both flushes 0, misalign_err=0, pc_next=RESET_VEC.
  - Reset asserted mid-fetch or mid-DRAIN discards the pending target.
- BOOT (first cycle after rst falls): pc_next=RESET_VEC, pc_we=1, imem_req=0, then go to RUN.
- RUN: imem_req=1 every cycle. Priority, highest first: br_taken, jmp, stall, sequential.
  - br_taken with imem_ready=1: pc_next=br_target, pc_we=1, if_id_flush=1, id_ex_flush=1. Stay in RUN.
  - jmp with imem_ready=1: pc_next=jmp_target, pc_we=1, if_id_flush=1, id_ex_flush=0. Stay in RUN.
  - Redirect (br_taken or jmp) with imem_ready=0:
    - Capture the winning target into pend_pc and assert the same flushes this cycle.
    - pc_we=0. Go to DRAIN.
  - stall (no redirect): pc_we=0, imem_req stays 1. Fetched data is held by the hazard unit, not here.
  - Otherwise, imem_ready=1: pc_next=pc_q+4, pc_we=1.
  - Otherwise, imem_ready=0: pc_we=0 and the address is held.
- DRAIN:
  - imem_req=1. br_taken, jmp and stall are ignored; the pipeline is already flushed.
  - imem_ready=0: stay in DRAIN, pc_we=0.
  - imem_ready=1: pc_next=pend_pc, pc_we=1, if_id_flush=1 (discard the stale instruction), then go to RUN.
- Latency:
  - One instruction per cycle when imem_ready is held high.
  - Redirect penalty: taken branch 2 bubbles, jump 1 bubble, plus any DRAIN wait cycles.
- Arithmetic: pc_q+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
- Alignment without the option: bits [1:0] of the redirect target are forced to 0.
- Handshake rule: pc_we is never asserted while imem_req=1 and imem_ready=0.

Optional Feature:
- Macro: PCSEQ_TRAP_EN.
- Defined: a redirect target with [1:0]!=0 is replaced by TRAP_VEC.
  - misalign_err pulses for one cycle, in the cycle the target is accepted (immediate redirect or DRAIN capture).
  - The flushes follow the originating redirect.
- Undefined: target low bits are cleared silently, misalign_err is tied 0, and TRAP_VEC is unused.

Decomposition:
- Package pc_seq_pkg:
  - typedef enum logic [1:0] pcseq_state_t {BOOT, RUN, DRAIN}.
  - Constants XLEN=32 and INSTR_BYTES=4.
- One combinational sub-module, pc_target_sel:
  - Inputs: br_taken/br_target, jmp/jmp_target.
  - Outputs: redirect, target (aligned or trapped), is_branch, misalign.
- FSM and pend_pc stay in pc_sequencer.

Test Plan:
- Boot, then imem_ready=1 for 4 cycles:
  - pc_next = 0x0 in BOOT.
  - Then pc_q+4 each cycle (0x4, 0x8, 0xC, 0x10) with pc_we=1.
- br_taken=1, br_target=0x40, together with jmp=1, jmp_target=0x80, imem_ready=1:
  - pc_next=0x40, pc_we=1, both flushes 1 for one cycle.
- jmp=1, jmp_target=0x200 with imem_ready=0 for 3 cycles:
  - if_id_flush=1 in the capture cycle, then DRAIN with pc_we=0 for 2 further cycles.
  - When imem_ready rises: pc_next=0x200, pc_we=1, if_id_flush=1.
- stall=1 for 2 cycles with imem_ready=1 at pc_q=0x20:
  - pc_we=0 and imem_req=1 throughout.
  - After stall falls: pc_next=0x24.
- pc_q=0xFFFF_FFFC, imem_ready=1: pc_next=0x0. Then assert rst mid-DRAIN: all outputs 0 immediately, BOOT reloads RESET_VEC.
- br_target=0x42:
  - With PCSEQ_TRAP_EN: pc_next=0x100, misalign_err=1.
  - Without it: pc_next=0x40, misalign_err=0.
